// File: rtl/spi_rr_scheduler.sv
// Round-robin scheduler sharing one SPI master between NUM_REQ requesters.
// Each grant owns the master for a burst of req_len+1 bytes.
module spi_rr_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int LEN_WIDTH    = 4,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            byte_ack,
   output logic                          rx_valid,
   output logic [DATA_WIDTH-1:0]         rx_data,
   output logic                          done,
   output logic                          error,
   output logic                          sched_busy,
   output logic                          spi_start,
   output logic [DATA_WIDTH-1:0]         spi_data_in,
   input  logic                          spi_busy,
   input  logic [DATA_WIDTH-1:0]         spi_data_out
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

   state_t               state;
   logic [IW-1:0]        ptr;
   logic [IW-1:0]        winner;
   logic [IW-1:0]        pick;
   logic [IW-1:0]        cand;
   logic                 found;
   int unsigned          k;
   logic [LEN_WIDTH-1:0] remaining;
   logic [TW-1:0]        tmo;

   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      k     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k    = (32'(ptr) + i) % 32'(NUM_REQ);
         cand = IW'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         winner      <= '0;
         remaining   <= '0;
         tmo         <= '0;
         grant       <= '0;
         byte_ack    <= '0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         sched_busy  <= 1'b0;
         spi_start   <= 1'b0;
         spi_data_in <= '0;
      end else begin
         spi_start <= 1'b0;
         byte_ack  <= '0;
         rx_valid  <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         case (state)
            IDLE: begin
               // First IDLE cycle after a burst only releases the grant,
               // so done and a new grant can never share a cycle.
               if (grant != '0) begin
                  grant      <= '0;
                  sched_busy <= 1'b0;
                  ptr        <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
               end else if (found) begin
                  winner     <= pick;
                  grant      <= NUM_REQ'(1) << pick;
                  sched_busy <= 1'b1;
                  remaining  <= req_len[pick*LEN_WIDTH +: LEN_WIDTH];
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (!spi_busy) begin
                  spi_start        <= 1'b1;
                  spi_data_in      <= tx_data[winner*DATA_WIDTH +: DATA_WIDTH];
                  byte_ack[winner] <= 1'b1;
                  tmo              <= '0;
                  state            <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (spi_busy) begin
                  state <= WAIT_DONE;
               end else begin
                  tmo <= tmo + 1'b1;
                  if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
                     error <= 1'b1;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            WAIT_DONE: begin
               if (!spi_busy) begin
                  rx_data  <= spi_data_out;
                  rx_valid <= 1'b1;
                  if (remaining == '0) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     remaining <= remaining - 1'b1;
                     state     <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_rr_scheduler.sv
// Bench for spi_rr_scheduler: vector table, hand sequences and randomized
// bursts against a round-robin reference model with a behavioural SPI slave.
module tb_spi_rr_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic [31:0] tx_data;
   logic [3:0]  grant, byte_ack;
   logic        rx_valid, done, error, sched_busy, spi_start, spi_busy;
   logic [7:0]  rx_data, spi_data_in, spi_data_out;

   logic [3:0]  lens [4];
   logic [7:0]  tx   [4];
   logic        slave_en;
   int          checks = 0;
   int          errors = 0;

   spi_rr_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .LEN_WIDTH(4), .BUSY_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .req(req), .req_len(req_len), .tx_data(tx_data),
      .grant(grant), .byte_ack(byte_ack), .rx_valid(rx_valid), .rx_data(rx_data),
      .done(done), .error(error), .sched_busy(sched_busy), .spi_start(spi_start),
      .spi_data_in(spi_data_in), .spi_busy(spi_busy), .spi_data_out(spi_data_out)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_len = '0;
      tx_data = '0;
      for (int i = 0; i < 4; i++) begin
         req_len[i*4 +: 4] = lens[i];
         tx_data[i*8 +: 8] = tx[i];
      end
   end

   // SPI slave: busy rises the cycle after start, lasts 1..4 cycles, replies data^FE.
   initial begin
      int cnt;
      logic [7:0] lat, d;
      logic s, rs;
      spi_busy = 1'b0; spi_data_out = '0; cnt = 0; lat = '0;
      forever begin
         @(posedge clk);
         s = spi_start; rs = reset; d = spi_data_in;
         #1;
         if (rs || !slave_en) begin
            spi_busy = 1'b0; cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               spi_busy = 1'b0; spi_data_out = lat ^ 8'hFE;
            end
         end else if (s) begin
            lat = d; spi_busy = 1'b1; cnt = int'($urandom_range(1, 4));
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int rr_pick(input int p, input logic [3:0] r);
      for (int j = 0; j < 4; j++)
         if (r[(p + j) % 4]) return (p + j) % 4;
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_grant(output bit got);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (grant != '0) got = 1'b1;
      end
   endtask

   task automatic run_burst(input int w, input int nbytes, input bit drop, input string nm);
      int starts, acks, rxs;
      bit got, fin;
      logic [7:0] sent [$];
      logic [31:0] oh;
      starts = 0; acks = 0; rxs = 0; fin = 1'b0;
      oh = 32'(1) << w;
      wait_grant(got);
      chk({nm, " grant"}, 32'(grant), oh);
      chk({nm, " sched_busy"}, 32'(sched_busy), 1);
      if (drop) req = '0;
      for (int c = 0; c < 20 * nbytes + 40 && !fin; c++) begin
         @(negedge clk);
         if (spi_start) begin
            chk({nm, " spi_data_in"}, 32'(spi_data_in), 32'(tx[w]));
            sent.push_back(tx[w]);
            starts++;
         end
         if (byte_ack != '0) begin
            chk({nm, " byte_ack"}, 32'(byte_ack), oh);
            acks++;
            tx[w] = tx[w] + 8'h11;
         end
         if (rx_valid) begin
            chk({nm, " rx_data"}, 32'(rx_data), (rxs < sent.size()) ? 32'(sent[rxs] ^ 8'hFE) : 32'hFFFF);
            rxs++;
         end
         if (done) begin
            fin = 1'b1;
            chk({nm, " error"}, 32'(error), 0);
            chk({nm, " grant at done"}, 32'(grant), oh);
         end
      end
      chk({nm, " done seen"}, 32'(fin), 1);
      chk({nm, " starts"}, starts, nbytes);
      chk({nm, " acks"}, acks, nbytes);
      chk({nm, " rx count"}, rxs, nbytes);
      @(negedge clk);
      chk({nm, " grant released"}, 32'(grant), 0);
      chk({nm, " sched_busy low"}, 32'(sched_busy), 0);
      chk({nm, " done single"}, 32'(done), 0);
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] len;
      logic [7:0] tx;
      int         exp_w;
      int         exp_bytes;
   } vec_t;

   initial begin
      vec_t vecs [8];
      int   held_seq [5];
      int   mptr, w, nb, gap, starts;
      bit   got, fin, saw_rx;
      logic [3:0] r;

      vecs[0] = '{4'b0001, 4'd0,  8'hAB, 0, 1};
      vecs[1] = '{4'b0010, 4'd2,  8'h11, 1, 3};
      vecs[2] = '{4'b0011, 4'd0,  8'h3C, 0, 1};
      vecs[3] = '{4'b0011, 4'd1,  8'h47, 1, 2};
      vecs[4] = '{4'b1000, 4'd15, 8'h01, 3, 16};
      vecs[5] = '{4'b0110, 4'd0,  8'h90, 1, 1};
      vecs[6] = '{4'b0101, 4'd1,  8'hA5, 2, 2};
      vecs[7] = '{4'b0101, 4'd0,  8'h5A, 0, 1};
      held_seq = '{0, 1, 2, 3, 0};

      req = '0; slave_en = 1'b1;
      for (int i = 0; i < 4; i++) begin lens[i] = '0; tx[i] = '0; end
      do_reset();
      @(negedge clk);
      chk("reset grant", 32'(grant), 0);
      chk("reset sched_busy", 32'(sched_busy), 0);
      chk("reset spi_start", 32'(spi_start), 0);
      chk("reset done", 32'(done), 0);
      chk("reset error", 32'(error), 0);
      chk("reset rx_valid", 32'(rx_valid), 0);
      chk("reset rx_data", 32'(rx_data), 0);
      chk("reset spi_data_in", 32'(spi_data_in), 0);
      chk("reset byte_ack", 32'(byte_ack), 0);

      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 4; i++) begin lens[i] = vecs[v].len; tx[i] = vecs[v].tx; end
         req = vecs[v].req;
         run_burst(vecs[v].exp_w, vecs[v].exp_bytes, 1'b1, $sformatf("vec%0d", v));
      end

      // All requesters held: strict rotation from reset.
      do_reset();
      for (int i = 0; i < 4; i++) lens[i] = '0;
      req = 4'b1111;
      for (int b = 0; b < 5; b++) run_burst(held_seq[b], 1, 1'b0, $sformatf("held%0d", b));
      req = '0;

      // Busy never rises: timeout after 15 WAIT_BUSY cycles, pointer 1 -> winner 2.
      slave_en = 1'b0;
      req = 4'b0100;
      wait_grant(got);
      chk("tmo grant", 32'(grant), 32'b0100);
      req = '0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (spi_start) got = 1'b1;
      end
      chk("tmo start seen", 32'(got), 1);
      gap = 0; fin = 1'b0; saw_rx = 1'b0; starts = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         gap++;
         if (spi_start) starts++;
         if (rx_valid) saw_rx = 1'b1;
         if (done) begin
            fin = 1'b1;
            chk("tmo error with done", 32'(error), 1);
            chk("tmo grant at done", 32'(grant), 32'b0100);
         end
      end
      chk("tmo done seen", 32'(fin), 1);
      chk("tmo cycles", gap, 15);
      chk("tmo no rx", 32'(saw_rx), 0);
      chk("tmo single start", starts, 0);
      @(negedge clk);
      chk("tmo grant cleared", 32'(grant), 0);
      chk("tmo error pulse", 32'(error), 0);
      slave_en = 1'b1;
      req = 4'b0101;
      run_burst(0, 1, 1'b1, "after tmo");

      // Randomized segments against the round-robin model.
      mptr = 1;
      for (int s = 0; s < 25; s++) begin
         r = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            lens[i] = 4'($urandom_range(0, 3));
            tx[i]   = 8'($urandom);
         end
         req = r;
         nb = int'($urandom_range(1, 3));
         for (int b = 0; b < nb; b++) begin
            w = rr_pick(mptr, r);
            run_burst(w, int'(lens[w]) + 1, 1'b0, $sformatf("rand%0d.%0d", s, b));
            mptr = (w + 1) % 4;
         end
         req = '0;
      end

      // Reset mid-burst with pointer at 1; afterwards arbitration restarts at 0.
      for (int i = 0; i < 4; i++) lens[i] = '0;
      req = 4'b0001;
      run_burst(0, 1, 1'b1, "pre reset");
      lens[1] = 4'd3;
      req = 4'b0010;
      wait_grant(got);
      chk("mid grant", 32'(grant), 32'b0010);
      req = '0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (spi_busy) got = 1'b1;
      end
      chk("mid busy seen", 32'(got), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid reset grant", 32'(grant), 0);
      chk("mid reset spi_start", 32'(spi_start), 0);
      chk("mid reset sched_busy", 32'(sched_busy), 0);
      chk("mid reset byte_ack", 32'(byte_ack), 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) lens[i] = '0;
      req = 4'b1111;
      run_burst(0, 1, 1'b1, "post reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
